// File: rtl/neuron_accumulator_pkg.sv
// Shared constants for the neuron accumulator datapath: widths, fixed-point
// format and FSM state encoding.
package neuron_accumulator_pkg;

  localparam int unsigned NA_DATA_W  = 16;
  localparam int unsigned NA_GUARD_W = 8;
  localparam int unsigned NA_ACC_W   = NA_DATA_W + NA_GUARD_W;
  localparam int unsigned NA_FRAC_W  = 7;

  localparam logic [1:0] ST_ACC  = 2'd0;
  localparam logic [1:0] ST_BIAS = 2'd1;
  localparam logic [1:0] ST_ACT  = 2'd2;
  localparam logic [1:0] ST_OUT  = 2'd3;

endpackage

// File: rtl/neuron_accumulator_sat_relu.sv
// Combinational signed saturation from IN_W down to OUT_W followed by optional
// ReLU; clip_c reports that saturation occurred, independent of ReLU.
module sat_relu
  import neuron_accumulator_pkg::*;
#(
  parameter int unsigned IN_W  = NA_ACC_W,
  parameter int unsigned OUT_W = NA_DATA_W
) (
  input  logic [IN_W-1:0]  acc,
  input  logic             relu,
  output logic [OUT_W-1:0] res_c,
  output logic             clip_c
);

  localparam int unsigned TOP_W = IN_W - OUT_W + 1;

  logic [TOP_W-1:0] top_bits;
  logic [OUT_W-1:0] sat_val;

  // In range only when every bit above the result sign matches it.
  always_comb begin
    top_bits = acc[IN_W-1:OUT_W-1];
    clip_c   = !((&top_bits) || !(|top_bits));
    if (!clip_c) begin
      sat_val = acc[OUT_W-1:0];
    end else if (acc[IN_W-1]) begin
      sat_val = {1'b1, {(OUT_W-1){1'b0}}};
    end else begin
      sat_val = {1'b0, {(OUT_W-1){1'b1}}};
    end
    res_c = (relu && sat_val[OUT_W-1]) ? '0 : sat_val;
  end

endmodule

// File: rtl/neuron_accumulator.sv
// Accumulates PE partial sums for one neuron, adds bias, then saturates and
// optionally applies ReLU before handing the result downstream.
module neuron_accumulator
  import neuron_accumulator_pkg::*;
#(
  parameter int unsigned DATA_W = NA_DATA_W,
  parameter int unsigned ACC_W  = NA_ACC_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  input  logic [DATA_W-1:0] bias,
  input  logic              act_relu,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              sat
);

  logic [1:0]        state_q, state_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic              first_q, first_d;
  logic [DATA_W-1:0] bias_q, bias_d;
  logic              relu_q, relu_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              sat_q, sat_d;

  logic [ACC_W-1:0]  in_ext;
  logic [ACC_W-1:0]  bias_ext;
  logic [DATA_W-1:0] res_c;
  logic              clip_c;
  logic              in_hs;

  assign in_ready  = (state_q == ST_ACC) && !clr && !rst;
  assign out_valid = (state_q == ST_OUT);
  assign out_data  = out_data_q;
  assign sat       = sat_q;
  assign in_hs     = in_valid && in_ready;
  assign in_ext    = {{(ACC_W-DATA_W){in_data[DATA_W-1]}}, in_data};
  assign bias_ext  = {{(ACC_W-DATA_W){bias_q[DATA_W-1]}}, bias_q};

  sat_relu #(
    .IN_W  (ACC_W),
    .OUT_W (DATA_W)
  ) u_sat_relu (
    .acc    (acc_q),
    .relu   (relu_q),
    .res_c  (res_c),
    .clip_c (clip_c)
  );

  // Next-state and datapath update; clr overrides every handshake.
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    first_d    = first_q;
    bias_d     = bias_q;
    relu_d     = relu_q;
    out_data_d = out_data_q;
    sat_d      = sat_q;
    if (clr) begin
      state_d    = ST_ACC;
      acc_d      = '0;
      first_d    = 1'b1;
      out_data_d = '0;
      sat_d      = 1'b0;
    end else begin
      case (state_q)
        ST_ACC: begin
          if (in_hs) begin
            acc_d   = first_q ? in_ext : acc_q + in_ext;
            first_d = 1'b0;
            if (in_last) begin
              bias_d  = bias;
              relu_d  = act_relu;
              state_d = ST_BIAS;
            end
          end
        end
        ST_BIAS: begin
          acc_d   = acc_q + bias_ext;
          state_d = ST_ACT;
        end
        ST_ACT: begin
          out_data_d = res_c;
          sat_d      = clip_c;
          state_d    = ST_OUT;
        end
        ST_OUT: begin
          if (out_ready) begin
            out_data_d = '0;
            first_d    = 1'b1;
            state_d    = ST_ACC;
          end
        end
        default: state_d = ST_ACC;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_ACC;
      acc_q      <= '0;
      first_q    <= 1'b1;
      bias_q     <= '0;
      relu_q     <= 1'b0;
      out_data_q <= '0;
      sat_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      first_q    <= first_d;
      bias_q     <= bias_d;
      relu_q     <= relu_d;
      out_data_q <= out_data_d;
      sat_q      <= sat_d;
    end
  end

endmodule

// File: tb/tb_neuron_accumulator.sv
// Self-checking bench: directed neurons with literal results plus randomized
// traffic compared every cycle against a plain-arithmetic neuron model.
module tb_neuron_accumulator;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clr = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_data = '0;
  logic        in_last = 1'b0;
  logic [15:0] bias = '0;
  logic        act_relu = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_data;
  logic        sat;

  int n_checks = 0;
  int n_fail   = 0;
  int rdy_mode = 0;

  neuron_accumulator #(.DATA_W(16), .ACC_W(24)) dut (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .bias      (bias),
    .act_relu  (act_relu),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .sat       (sat)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Neuron result from plain integer arithmetic: wrap to 24 bits, clamp, ReLU.
  function automatic void calc(input longint s, input bit r,
                               output logic [15:0] d, output logic st);
    longint w;
    w = s & 64'h0000_0000_00FF_FFFF;
    if (w >= 64'sd8388608) w = w - 64'sd16777216;
    if (w > 64'sd32767) begin
      d = 16'h7FFF; st = 1'b1;
    end else if (w < -64'sd32768) begin
      d = 16'h8000; st = 1'b1;
    end else begin
      d = 16'(w); st = 1'b0;
    end
    if (r && d[15]) d = 16'h0000;
  endfunction

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ($urandom_range(0, 2) != 0);
      default: out_ready = 1'b0;
    endcase
  end

  // Model state: running sum, and a finished result waiting to be delivered.
  longint      m_sum = 0;
  bit          m_pend = 1'b0;
  int          m_due = 0;
  logic [15:0] m_d = '0;
  logic        m_s = 1'b0;
  logic        m_last_sat = 1'b0;
  int          cyc = 0;

  always begin
    bit acc_ok, out_ok, exp_valid;
    @(posedge clk);
    cyc++;
    if (rst || clr) begin
      m_sum = 0; m_pend = 1'b0; m_last_sat = 1'b0;
    end else begin
      acc_ok = in_valid && !m_pend;
      out_ok = m_pend && (cyc - 1 >= m_due) && out_ready;
      if (out_ok) m_pend = 1'b0;
      if (acc_ok) begin
        m_sum = m_sum + longint'($signed(in_data));
        if (in_last) begin
          m_sum = m_sum + longint'($signed(bias));
          calc(m_sum, act_relu, m_d, m_s);
          m_pend = 1'b1;
          m_due  = cyc + 2;
          m_sum  = 0;
        end
      end
    end
    @(negedge clk);
    if (rst) begin
      m_sum = 0; m_pend = 1'b0; m_last_sat = 1'b0;
    end
    exp_valid = m_pend && (cyc >= m_due);
    if (exp_valid) m_last_sat = m_s;
    chk("out_valid", 32'(out_valid), 32'(exp_valid));
    chk("out_data", 32'(out_data), exp_valid ? 32'(m_d) : 32'h0);
    chk("sat", 32'(sat), 32'(m_last_sat));
    chk("in_ready", 32'(in_ready), 32'(!m_pend && !rst && !clr));
  end

  task automatic send_beat(input logic [15:0] d, input bit last,
                           input logic [15:0] b, input bit r, input int gap);
    bit acc;
    int n;
    in_valid = 1'b0;
    if (gap > 0) begin
      repeat (gap) @(posedge clk);
      #1;
    end
    in_valid = 1'b1; in_data = d; in_last = last; bias = b; act_relu = r;
    acc = 1'b0; n = 0;
    while (!acc && n < 500) begin
      @(posedge clk);
      acc = in_ready;
      n++;
      #1;
    end
    in_valid = 1'b0; in_last = 1'b0;
    if (!acc) chk("beat_accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_out(output logic [15:0] d, output logic s);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 200);
    if (!out_valid) chk("out_valid_timeout", 32'd0, 32'd1);
    d = out_data;
    s = sat;
  endtask

  task automatic one_beat(input logic [15:0] d, input logic [15:0] b, input bit r,
                          input logic [15:0] exp_d, input logic exp_s, input string nm);
    logic [15:0] got_d;
    logic        got_s;
    send_beat(d, 1'b1, b, r, 0);
    wait_out(got_d, got_s);
    chk({nm, "_data"}, 32'(got_d), 32'(exp_d));
    chk({nm, "_sat"}, 32'(got_s), 32'(exp_s));
  endtask

  initial begin
    logic [15:0] got_d;
    logic        got_s;
    int          nb;
    logic [15:0] d, b;

    // Reset state
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_sat", 32'(sat), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);

    // 0x80+0x100-0x80+0x80+0x40 = 0x1C0, result lands on the 3rd edge counting the handshake
    send_beat(16'h0080, 1'b0, 16'h0, 1'b1, 0);
    send_beat(16'h0100, 1'b0, 16'h0, 1'b1, 1);
    send_beat(16'hFF80, 1'b0, 16'h0, 1'b1, 0);
    send_beat(16'h0080, 1'b1, 16'h0040, 1'b1, 0);
    @(negedge clk);
    chk("lat_e0_valid", 32'(out_valid), 32'd0);
    chk("lat_e0_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    chk("lat_e1_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    chk("lat_e2_valid", 32'(out_valid), 32'd1);
    chk("four_beat_data", 32'(out_data), 32'h01C0);
    chk("four_beat_sat", 32'(sat), 32'd0);
    @(posedge clk); #1;

    send_beat(16'h7000, 1'b0, 16'h0, 1'b0, 0);
    one_beat(16'h7000, 16'h0000, 1'b0, 16'h7FFF, 1'b1, "pos_sat");
    send_beat(16'h9000, 1'b0, 16'h0, 1'b0, 0);
    one_beat(16'h9000, 16'h0000, 1'b0, 16'h8000, 1'b1, "neg_sat");
    send_beat(16'h9000, 1'b0, 16'h0, 1'b1, 0);
    one_beat(16'h9000, 16'h0000, 1'b1, 16'h0000, 1'b1, "neg_sat_relu");
    one_beat(16'hFF00, 16'h0000, 1'b1, 16'h0000, 1'b0, "single_relu");
    one_beat(16'hFF00, 16'h0000, 1'b0, 16'hFF00, 1'b0, "single_ident");

    // Output backpressure with an upstream beat waiting
    rdy_mode = 2;
    send_beat(16'h0100, 1'b1, 16'h0000, 1'b0, 0);
    wait_out(got_d, got_s);
    chk("stall_first", 32'(got_d), 32'h0100);
    in_valid = 1'b1; in_data = 16'h0020; in_last = 1'b1; bias = 16'h0; act_relu = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_valid", 32'(out_valid), 32'd1);
      chk("stall_data", 32'(out_data), 32'h0100);
      chk("stall_in_ready", 32'(in_ready), 32'd0);
    end
    rdy_mode = 0;
    one_beat(16'h0020, 16'h0000, 1'b0, 16'h0020, 1'b0, "after_stall");

    // clr after two beats discards the partial sum
    send_beat(16'h1000, 1'b0, 16'h0, 1'b0, 0);
    send_beat(16'h2000, 1'b0, 16'h0, 1'b0, 0);
    clr = 1'b1;
    @(negedge clk);
    chk("clr_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1 clr = 1'b0;
    @(negedge clk);
    chk("clr_out_data", 32'(out_data), 32'd0);
    chk("clr_sat", 32'(sat), 32'd0);
    one_beat(16'h0010, 16'h0000, 1'b0, 16'h0010, 1'b0, "after_clr");

    // Reset while a result is held in OUT
    rdy_mode = 2;
    send_beat(16'h7FFF, 1'b0, 16'h0, 1'b0, 0);
    send_beat(16'h7FFF, 1'b1, 16'h0, 1'b0, 0);
    wait_out(got_d, got_s);
    chk("pre_rst_sat", 32'(got_s), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_data", 32'(out_data), 32'd0);
    chk("mid_rst_sat", 32'(sat), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    rdy_mode = 0;
    one_beat(16'h0010, 16'h0000, 1'b0, 16'h0010, 1'b0, "after_rst");

    // Randomized neurons with input gaps and output backpressure
    rdy_mode = 1;
    for (int k = 0; k < 200; k++) begin
      nb = $urandom_range(1, 5);
      for (int j = 0; j < nb; j++) begin
        d = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($signed(10'($urandom)));
        b = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($signed(9'($urandom)));
        send_beat(d, j == nb - 1, b, 1'($urandom), $urandom_range(0, 2));
      end
    end
    rdy_mode = 0;
    repeat (20) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
